fir_mac_filter: RTL and testbench

FIR_MAC_FILTER -- requirements
Module: fir_mac_filter

---
 rtl/fir_pkg.sv | 17 +
 rtl/fir_tap_mac.sv | 32 +++
 rtl/fir_mac_filter.sv | 131 +++++++++++++
 tb/tb_fir_mac_filter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and helpers for the FIR multiply-accumulate filter.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Result width that holds a full-precision sum of taps products without overflow.
    function automatic int unsigned acc_width(input int unsigned data_w,
                                              input int unsigned coef_w,
                                              input int unsigned taps);
        return data_w + coef_w + $clog2(taps);
    endfunction

endpackage

// File: rtl/fir_tap_mac.sv
// Single signed multiplier feeding a clearable accumulator.
module fir_tap_mac #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned COEF_W = 8,
    parameter int unsigned ACC_W  = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] x,
    input  logic [COEF_W-1:0] c,
    output logic [ACC_W-1:0]  acc
);

    localparam int unsigned PROD_W = DATA_W + COEF_W;

    logic signed [PROD_W-1:0] prod_c;

    assign prod_c = PROD_W'($signed(x)) * PROD_W'($signed(c));

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + ACC_W'(prod_c);
        end
    end

endmodule

// File: rtl/fir_mac_filter.sv
// Time-multiplexed FIR filter: one sample in, TAPS serial MAC cycles, one result out.
module fir_mac_filter
    import fir_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned COEF_W = 8,
    parameter int unsigned TAPS   = 8,
    parameter int unsigned ACC_W  = acc_width(DATA_W, COEF_W, TAPS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    data_en,
    input  logic [DATA_W-1:0]       data,
    output logic                    ready,
    input  logic                    coef_we,
    input  logic [$clog2(TAPS)-1:0] coef_addr,
    input  logic [COEF_W-1:0]       coef_data,
    output logic [ACC_W-1:0]        result,
    output logic                    result_valid,
    output logic                    overrun
);

    localparam int unsigned IDX_W = $clog2(TAPS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS - 1);

    state_t            state, state_d;
    logic [IDX_W-1:0]  idx, idx_d;
    logic              accept_c, drop_c, mac_en_c, done_c;

    logic [DATA_W-1:0] xline [TAPS];
    logic [COEF_W-1:0] coef  [TAPS];
    logic [ACC_W-1:0]  acc;

    // Next-state and control decode.
    always_comb begin
        state_d  = state;
        idx_d    = idx;
        accept_c = 1'b0;
        drop_c   = 1'b0;
        mac_en_c = 1'b0;
        done_c   = 1'b0;
        case (state)
            IDLE: begin
                if (data_en) begin
                    accept_c = 1'b1;
                    state_d  = MAC;
                    idx_d    = '0;
                end
            end
            MAC: begin
                mac_en_c = 1'b1;
                drop_c   = data_en;
                if (idx == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx + IDX_W'(1);
                end
            end
            DONE: begin
                done_c  = 1'b1;
                drop_c  = data_en;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            ready <= 1'b1;
        end else begin
            state <= state_d;
            idx   <= idx_d;
            ready <= (state_d == IDLE);
        end
    end

    // Delay line, coefficient store and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            result       <= '0;
            result_valid <= 1'b0;
            overrun      <= 1'b0;
            for (int k = 0; k < int'(TAPS); k++) begin
                xline[k] <= '0;
                if (k == 0) begin
                    coef[k] <= COEF_W'(1);
                end else begin
                    coef[k] <= '0;
                end
            end
        end else begin
            result_valid <= done_c;
            if (done_c) begin
                result <= acc;
            end
            if (drop_c) begin
                overrun <= 1'b1;
            end
            if (accept_c) begin
                xline[0] <= data;
                for (int k = 1; k < int'(TAPS); k++) begin
                    xline[k] <= xline[k-1];
                end
            end
            // Writes land before the first MAC cycle, so a same-edge write applies to that sample.
            if (coef_we && ready) begin
                coef[coef_addr] <= coef_data;
            end
        end
    end

    fir_tap_mac #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (accept_c),
        .en  (mac_en_c),
        .x   (xline[idx]),
        .c   (coef[idx]),
        .acc (acc)
    );

endmodule

// File: tb/tb_fir_mac_filter.sv
// Directed self-checking bench for fir_mac_filter with default parameters.
module tb_fir_mac_filter;

    localparam int TAPS = 8;
    localparam int LAT  = TAPS + 1;

    logic        clk;
    logic        rst;
    logic        data_en;
    logic [7:0]  data;
    logic        ready;
    logic        coef_we;
    logic [2:0]  coef_addr;
    logic [7:0]  coef_data;
    logic [18:0] result;
    logic        result_valid;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    fir_mac_filter dut (
        .clk          (clk),
        .rst          (rst),
        .data_en      (data_en),
        .data         (data),
        .ready        (ready),
        .coef_we      (coef_we),
        .coef_addr    (coef_addr),
        .coef_data    (coef_data),
        .result       (result),
        .result_valid (result_valid),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic send(input int d);
        data_en = 1'b1;
        data    = 8'(d);
        tick();
        data_en = 1'b0;
    endtask

    task automatic write_coef(input int a, input int v);
        coef_we   = 1'b1;
        coef_addr = 3'(a);
        coef_data = 8'(v);
        tick();
        coef_we = 1'b0;
    endtask

    // Returns the number of edges until result_valid is seen, or -1 on timeout.
    task automatic wait_valid(input int maxc, output int n);
        n = -1;
        for (int i = 1; i <= maxc; i++) begin
            tick();
            if (result_valid === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
        checks++; if (result !== 19'd0) begin errors++; $display("FAIL reset_result got %0d want 0", result); end
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", result_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
        rst = 1'b0;
    endtask

    task automatic test_passthrough();
        int samples [3] = '{23, 1, 45};
        int n;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send(samples[i]);
            checks++; if (ready !== 1'b0) begin errors++; $display("FAIL pass_busy[%0d] got ready=%b want 0", i, ready); end
            wait_valid(20, n);
            checks++; if (n != LAT) begin errors++; $display("FAIL pass_latency[%0d] got %0d want %0d", i, n, LAT); end
            checks++; if (result !== 19'(samples[i])) begin errors++; $display("FAIL pass_result[%0d] got %0d want %0d", i, result, samples[i]); end
            tick();
            checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL pass_pulse[%0d] got %b want 0", i, result_valid); end
            checks++; if (result !== 19'(samples[i])) begin errors++; $display("FAIL pass_hold[%0d] got %0d want %0d", i, result, samples[i]); end
        end
    endtask

    task automatic test_impulse();
        int n;
        do_reset();
        for (int k = 0; k < TAPS; k++) write_coef(k, k + 1);
        for (int i = 0; i <= TAPS; i++) begin
            send(i == 0 ? 1 : 0);
            wait_valid(20, n);
            checks++; if (n != LAT) begin errors++; $display("FAIL imp_latency[%0d] got %0d want %0d", i, n, LAT); end
            checks++; if (result !== 19'(i < TAPS ? i + 1 : 0)) begin
                errors++; $display("FAIL imp_result[%0d] got %0d want %0d", i, result, (i < TAPS ? i + 1 : 0));
            end
        end
    endtask

    task automatic test_max_neg();
        int n;
        do_reset();
        for (int k = 0; k < TAPS; k++) write_coef(k, -128);
        for (int i = 1; i <= TAPS; i++) begin
            send(-128);
            wait_valid(20, n);
            checks++; if (result !== 19'(i * 16384) || n != LAT) begin
                errors++; $display("FAIL maxneg[%0d] got %0d lat %0d want %0d lat %0d", i, result, n, i * 16384, LAT);
            end
        end
        checks++; if (result[18] !== 1'b0) begin errors++; $display("FAIL maxneg_sign got %b want 0", result[18]); end
    endtask

    task automatic test_overrun();
        int n;
        do_reset();
        send(10);
        tick();
        tick();
        send(99);
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b want 1", overrun); end
        wait_valid(20, n);
        checks++; if (n != LAT - 3) begin errors++; $display("FAIL ovr_latency got %0d want %0d", n, LAT - 3); end
        checks++; if (result !== 19'd10) begin errors++; $display("FAIL ovr_result got %0d want 10", result); end
        write_coef(0, 0);
        write_coef(1, 1);
        send(0);
        wait_valid(20, n);
        checks++; if (result !== 19'd10) begin errors++; $display("FAIL ovr_line got %0d want 10", result); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b want 1", overrun); end
    endtask

    task automatic test_reset_mid_mac();
        int n;
        do_reset();
        write_coef(0, 2);
        write_coef(1, 1);
        send(5);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got %b want 1", ready); end
        checks++; if (result !== 19'd0) begin errors++; $display("FAIL rmid_result got %0d want 0", result); end
        wait_valid(15, n);
        checks++; if (n != -1) begin errors++; $display("FAIL rmid_novalid got pulse at %0d want none", n); end
        send(3);
        wait_valid(20, n);
        checks++; if (result !== 19'd3) begin errors++; $display("FAIL rmid_coef0 got %0d want 3", result); end
        send(7);
        wait_valid(20, n);
        checks++; if (result !== 19'd7) begin errors++; $display("FAIL rmid_coef1 got %0d want 7", result); end
    endtask

    task automatic test_coef_busy();
        int n;
        do_reset();
        send(0);
        tick();
        write_coef(0, 5);
        wait_valid(20, n);
        checks++; if (result !== 19'd0 || n < 0) begin errors++; $display("FAIL busy_first got %0d lat %0d want 0", result, n); end
        send(1);
        wait_valid(20, n);
        checks++; if (result !== 19'd1) begin errors++; $display("FAIL busy_ignored got %0d want 1", result); end
    endtask

    task automatic test_same_edge_coef();
        int n;
        do_reset();
        coef_we   = 1'b1;
        coef_addr = 3'd0;
        coef_data = 8'd3;
        send(4);
        coef_we = 1'b0;
        wait_valid(20, n);
        checks++; if (result !== 19'd12 || n != LAT) begin errors++; $display("FAIL same_edge got %0d lat %0d want 12 lat %0d", result, n, LAT); end
    endtask

    initial begin
        rst       = 1'b1;
        data_en   = 1'b0;
        data      = '0;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        test_reset();
        test_passthrough();
        test_impulse();
        test_max_neg();
        test_overrun();
        test_reset_mid_mac();
        test_coef_busy();
        test_same_edge_coef();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
